// File: rtl/clock_period_meter.sv
// Measures the period of a slow asynchronous square wave in clk cycles between synchronized rising edges.
// Results register together; valid pulses SYNC_STAGES+2 cycles after the sig_in rising edge.
module clock_period_meter #(
   parameter int CNT_W       = 27,
   parameter int SEL_W       = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [SEL_W-1:0] sel_est,
   output logic             exact,
   output logic             valid,
   output logic             timeout
);

   typedef enum logic {ST_IDLE, ST_MEASURE} state_t;

   localparam logic [CNT_W-1:0] CNT_TERM = {{(CNT_W-1){1'b1}}, 1'b0};

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_dly;
   logic                   r_rise;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       r_period;
   logic [SEL_W-1:0]       r_sel;
   logic                   r_exact;
   logic                   r_valid;
   logic                   r_timeout;

   logic                   w_sync_out;
   logic [CNT_W-1:0]       w_nxt;
   logic [SEL_W-1:0]       w_sel;
   logic                   w_exact;

   assign w_sync_out = r_sync[SYNC_STAGES-1];

   // The rise pulse is registered so the FSM sees a clean single-cycle event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_dly  <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
         r_dly  <= w_sync_out;
         r_rise <= w_sync_out & ~r_dly;
      end
   end

   assign w_nxt   = r_cnt + CNT_W'(1);
   assign w_exact = (w_nxt != '0) && ((w_nxt & (w_nxt - CNT_W'(1))) == '0);

   always_comb begin
      w_sel = '0;
      for (int i = 1; i < CNT_W; i++) begin
         if (w_nxt[i]) w_sel = SEL_W'(i - 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_period  <= '0;
         r_sel     <= '0;
         r_exact   <= 1'b0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (!en) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_cnt <= '0;
                  if (r_rise) r_state <= ST_MEASURE;
               end
               ST_MEASURE: begin
                  // A rise on the terminal count still reports, so it is tested first.
                  if (r_rise) begin
                     r_period  <= w_nxt;
                     r_sel     <= w_sel;
                     r_exact   <= w_exact;
                     r_valid   <= 1'b1;
                     r_timeout <= 1'b0;
                     r_cnt     <= '0;
                  end else if (r_cnt == CNT_TERM) begin
                     r_timeout <= 1'b1;
                     r_cnt     <= '0;
                     r_state   <= ST_IDLE;
                  end else begin
                     r_cnt <= w_nxt;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign period  = r_period;
   assign sel_est = r_sel;
   assign exact   = r_exact;
   assign valid   = r_valid;
   assign timeout = r_timeout;

endmodule

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
- Measures the period of a slow, asynchronous square wave in main-clock cycles. The typical source is a divided clock tapped from a counter bit.
- Reports the raw period, plus the divider select value that would produce it (period = 2^(sel+1) cycles).
- Provides loop-back self-check of the on-chip divider, and lets the controller auto-detect an externally supplied tick rate.

Parameters:
- CNT_W, 27, width of the period counter and period output; max reportable period is 2^CNT_W-1 cycles (covers sel=25, period 2^26).
- SEL_W, 5, width of sel_est.
- SYNC_STAGES, 2, synchronizer flops on sig_in (legal values 2 or 3).

Ports:
- clk  input  1  main clock; all logic on rising edge.
- rst_n  input  1  asynchronous reset, active low.
- en  input  1  measurement enable; low forces IDLE.
- sig_in  input  1  asynchronous signal to measure.
- period  output  CNT_W  last measured period in clk cycles, registered.
- sel_est  output  SEL_W  floor(log2(period))-1, registered.
- exact  output  1  period is an exact power of two.
- valid  output  1  one-cycle pulse when period/sel_est/exact update.
- timeout  output  1  sticky flag: no rising edge within the max period.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, all sync/edge flops=0; period=0, sel_est=0, exact=0, valid=0, timeout=0. Reset mid-measurement discards the partial count.
- Input path:
  - sig_in passes through SYNC_STAGES flops, then one delay flop.
  - rise = sync_out & ~delayed, one cycle per synchronized rising edge.
  - Falling edges are ignored, so duty cycle is irrelevant.
- FSM states:
  - IDLE: cnt held at 0; no outputs change. en=1 & rise -> MEASURE with cnt<=0. A first edge never produces valid.
  - MEASURE, no rise: cnt<=cnt+1.
  - MEASURE, rise: period<=cnt+1; sel_est, exact, valid=1 and timeout<=0 all take effect in the next cycle; cnt<=0; stay in MEASURE.
  - MEASURE, cnt==2^CNT_W-2 and no rise: timeout<=1, go to IDLE; no valid, period unchanged.
  - MEASURE, rise and that terminal count in the same cycle: rise wins; period=2^CNT_W-1, no timeout.
  - Any state, en=0: go to IDLE and clear cnt. Registered outputs and timeout hold their values. valid does not fire.
- Period arithmetic:
  - Edges N clk cycles apart give period=N.
  - The minimum observable N is 2, since the synchronized signal must be low at least one cycle.
- sel_est:
  - sel_est = (index of MSB set in the new period) - 1.
  - N=2 or 3 -> 0; N=1024 -> 9; N=2^26 -> 25.
  - Computed combinationally from cnt+1 and registered alongside period.
- exact: 1 iff the new period has exactly one bit set.
- valid timing:
  - valid is high exactly one cycle and never on two consecutive cycles.
  - Latency from the sig_in rising edge to valid is SYNC_STAGES+2 cycles, with sig_in meeting setup.
- timeout:
  - Cleared only by the next valid measurement or by reset.
  - en toggling does not clear it.

Test Plan:
- Reset, en=1, sig_in square wave toggling every clk cycle (period 2) -> no valid on first edge; then valid every 2 cycles with period=2, sel_est=0, exact=1.
- Square wave with period 1024 cycles (divider sel=9 loop-back) -> period=1024, sel_est=9, exact=1. Valid lands SYNC_STAGES+2 cycles after each sig_in rise, one cycle wide.
- Square wave with period 1000 cycles, 30% duty -> period=1000, sel_est=8, exact=0; duty cycle has no effect.
- CNT_W=8, one edge, then sig_in held low -> timeout=1 when cnt reaches 254, state IDLE, period unchanged. The next two edges 10 cycles apart -> period=10, sel_est=2, timeout=0.
- CNT_W=8, edges exactly 255 cycles apart -> period=255, sel_est=6, timeout stays 0 (rise-wins case).
- rst_n pulsed low mid-measurement (period 64 stream) -> all outputs 0 immediately. The first post-reset edge gives no valid; the second gives period=64, sel_est=5.
- en dropped for 50 cycles mid-stream -> no valid while low; outputs hold. After en=1, the first valid comes on the second edge.
